// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the MEM/WB stage.
// Contents: datapath constants, RV32I load funct3 encoding, and the MEM/WB payload bundle.
package pipeline_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RD_W = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef struct packed {
        logic            reg_write;
        logic            mem_to_rgs;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] read_data;
        logic            misalign;
    } memwb_bundle_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side input bundle with valid/ready, stall/flush, WB-side outputs.
// Modports: master = MEM/WB environment (drives in_*, flush, stall), slave = the stage.
interface mem_wb_stage_if;
    import pipeline_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic            in_reg_write;
    logic            in_mem_to_rgs;
    logic [RD_W-1:0] in_rd;
    logic [XLEN-1:0] in_result;
    logic [XLEN-1:0] in_read_data;
    logic [2:0]      in_funct3;
    logic [1:0]      in_addr_lo;
    logic            flush;
    logic            stall;
    logic            out_valid;
    logic            out_reg_write;
    logic            out_mem_to_rgs;
    logic [RD_W-1:0] out_rd;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_read_data;
    logic            out_misalign;

    modport master (
        output in_valid, in_reg_write, in_mem_to_rgs, in_rd, in_result,
               in_read_data, in_funct3, in_addr_lo, flush, stall,
        input  in_ready, out_valid, out_reg_write, out_mem_to_rgs, out_rd,
               out_result, out_read_data, out_misalign
    );

    modport slave (
        input  in_valid, in_reg_write, in_mem_to_rgs, in_rd, in_result,
               in_read_data, in_funct3, in_addr_lo, flush, stall,
        output in_ready, out_valid, out_reg_write, out_mem_to_rgs, out_rd,
               out_result, out_read_data, out_misalign
    );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// load_align: combinational load-data extraction and misalignment detection.
// Ports: raw_i (memory word), funct3_i (load size/sign), addr_lo_i (byte offset)
//        -> read_data_c_o (extended data), misalign_c_o (offset illegal for size).
module load_align
    import pipeline_pkg::*;
(
    input  logic [XLEN-1:0] raw_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] read_data_c_o,
    output logic            misalign_c_o
);

    logic [XLEN-1:0] byte_shift;
    logic [XLEN-1:0] half_shift;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    // Halfword selection uses only addr_lo[1]; an odd offset is flagged, not corrected.
    always_comb begin
        byte_shift    = raw_i >> {addr_lo_i, 3'b000};
        half_shift    = raw_i >> {addr_lo_i[1], 4'b0000};
        byte_sel      = byte_shift[7:0];
        half_sel      = half_shift[15:0];
        read_data_c_o = '0;
        misalign_c_o  = 1'b0;
        case (load_funct3_e'(funct3_i))
            LB:  read_data_c_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU: read_data_c_o = {{(XLEN-8){1'b0}}, byte_sel};
            LH: begin
                read_data_c_o = {{(XLEN-16){half_sel[15]}}, half_sel};
                misalign_c_o  = addr_lo_i[0];
            end
            LHU: begin
                read_data_c_o = {{(XLEN-16){1'b0}}, half_sel};
                misalign_c_o  = addr_lo_i[0];
            end
            LW: begin
                read_data_c_o = raw_i;
                misalign_c_o  = (addr_lo_i != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with valid/ready, stall and flush.
// Ports: clk, reset (async active-high), bus (mem_wb_stage_if.slave: in_* bundle with
//        in_valid/in_ready, flush, stall, out_* registered writeback bundle).
// Option: MEMWB_SKID_EN adds a one-entry skid buffer and makes in_ready a flop output.
module mem_wb_stage
    import pipeline_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mem_wb_stage_if.slave  bus
);

    logic [XLEN-1:0] align_data;
    logic            align_misalign;
    logic            misalign;
    logic            in_ready_c;
    logic            accept;
    logic            consume;
    memwb_bundle_t   in_bundle;
    memwb_bundle_t   main_q, main_d;
    logic            main_valid_q, main_valid_d;
`ifdef MEMWB_SKID_EN
    memwb_bundle_t   skid_q, skid_d;
    logic            skid_valid_q, skid_valid_d;
`endif

    load_align u_load_align (
        .raw_i         (bus.in_read_data),
        .funct3_i      (bus.in_funct3),
        .addr_lo_i     (bus.in_addr_lo),
        .read_data_c_o (align_data),
        .misalign_c_o  (align_misalign)
    );

    // Incoming bundle: misalignment only matters for loads; writes to x0 or misaligned loads are dropped.
    assign misalign             = bus.in_mem_to_rgs && align_misalign;
    assign in_bundle.reg_write  = bus.in_reg_write && (bus.in_rd != '0) && !misalign;
    assign in_bundle.mem_to_rgs = bus.in_mem_to_rgs;
    assign in_bundle.rd         = bus.in_rd;
    assign in_bundle.result     = bus.in_result;
    assign in_bundle.read_data  = bus.in_mem_to_rgs ? align_data : '0;
    assign in_bundle.misalign   = misalign;

`ifdef MEMWB_SKID_EN
    assign in_ready_c = !skid_valid_q;
`else
    assign in_ready_c = !main_valid_q || !bus.stall;
`endif

    assign accept  = bus.in_valid && in_ready_c;
    assign consume = main_valid_q && !bus.stall;

    // Next-state: flush > transfer > drain > hold; an emptied entry is zeroed so out_* read 0.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
`ifdef MEMWB_SKID_EN
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            main_d       = '0;
            main_valid_d = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (consume) begin
                main_d       = skid_q;
                skid_d       = '0;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || consume) begin
                main_d       = in_bundle;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_bundle;
                skid_valid_d = 1'b1;
            end
        end else if (consume) begin
            main_d       = '0;
            main_valid_d = 1'b0;
        end
`else
        if (bus.flush) begin
            main_d       = '0;
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_d       = in_bundle;
            main_valid_d = 1'b1;
        end else if (consume) begin
            main_d       = '0;
            main_valid_d = 1'b0;
        end
`endif
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
`ifdef MEMWB_SKID_EN
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
`endif
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
`ifdef MEMWB_SKID_EN
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
`endif
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = main_valid_q;
    assign bus.out_reg_write  = main_q.reg_write;
    assign bus.out_mem_to_rgs = main_q.mem_to_rgs;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_result     = main_q.result;
    assign bus.out_read_data  = main_q.read_data;
    assign bus.out_misalign   = main_q.misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus randomized traffic
// against a queue-based reference model of the held entries.
module tb_mem_wb_stage;
    import pipeline_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    memwb_bundle_t   q[$];
    logic [RD_W-1:0] wb_log[$];

    mem_wb_stage_if bus();

    mem_wb_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference extraction from the load rules, using plain integer arithmetic.
    function automatic memwb_bundle_t model(input logic rw, input logic m2r, input logic [RD_W-1:0] rd,
                                            input logic [31:0] res, input logic [31:0] word,
                                            input logic [2:0] f3, input logic [1:0] lo);
        memwb_bundle_t e;
        int unsigned b, h, ext;
        logic mis;
        b   = (word >> (8 * lo)) & 32'hFF;
        h   = (word >> (16 * (lo / 2))) & 32'hFFFF;
        ext = 0;
        mis = 1'b0;
        case (f3)
            3'd0: ext = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4: ext = b;
            3'd1: begin ext = (h >= 32768) ? h + 32'hFFFF_0000 : h; mis = (lo % 2) == 1; end
            3'd5: begin ext = h; mis = (lo % 2) == 1; end
            3'd2: begin ext = word; mis = (lo != 0); end
            default: ext = 0;
        endcase
        mis         = m2r && mis;
        e.reg_write = rw && (rd != 0) && !mis;
        e.mem_to_rgs = m2r;
        e.rd        = rd;
        e.result    = res;
        e.read_data = m2r ? ext : 32'd0;
        e.misalign  = mis;
        return e;
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model for the coming edge.
    task automatic score();
        logic exp_ready, xfer, cons;
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_reg_write", 32'(bus.out_reg_write), 32'(q[0].reg_write));
            check("out_mem_to_rgs", 32'(bus.out_mem_to_rgs), 32'(q[0].mem_to_rgs));
            check("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
            check("out_result", bus.out_result, q[0].result);
            check("out_read_data", bus.out_read_data, q[0].read_data);
            check("out_misalign", 32'(bus.out_misalign), 32'(q[0].misalign));
        end else begin
            check("idle_reg_write", 32'(bus.out_reg_write), 32'd0);
            check("idle_misalign", 32'(bus.out_misalign), 32'd0);
        end
`ifdef MEMWB_SKID_EN
        exp_ready = (q.size() < 2);
`else
        exp_ready = (q.size() == 0) || !bus.stall;
`endif
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        xfer = bus.in_valid && exp_ready;
        cons = (q.size() != 0) && !bus.stall;
        if (bus.flush) begin
            q.delete();
        end else begin
            if (cons) begin
                wb_log.push_back(q[0].rd);
                void'(q.pop_front());
            end
            if (xfer)
                q.push_back(model(bus.in_reg_write, bus.in_mem_to_rgs, bus.in_rd, bus.in_result,
                                  bus.in_read_data, bus.in_funct3, bus.in_addr_lo));
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), score, advance to next edge.
    task automatic apply(input logic v, input logic rw, input logic m2r, input logic [RD_W-1:0] rd,
                         input logic [31:0] res, input logic [31:0] word, input logic [2:0] f3,
                         input logic fl, input logic st);
        bus.in_valid      = v;
        bus.in_reg_write  = rw;
        bus.in_mem_to_rgs = m2r;
        bus.in_rd         = rd;
        bus.in_result     = res;
        bus.in_read_data  = word;
        bus.in_funct3     = f3;
        bus.in_addr_lo    = res[1:0];
        bus.flush         = fl;
        bus.stall         = st;
        #4;
        score();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st);
        apply(1'b0, 1'b0, 1'b0, '0, 32'd0, 32'd0, 3'd0, 1'b0, st);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_reg_write"}, 32'(bus.out_reg_write), 32'd0);
        check({tag, "_mem_to_rgs"}, 32'(bus.out_mem_to_rgs), 32'd0);
        check({tag, "_rd"}, 32'(bus.out_rd), 32'd0);
        check({tag, "_result"}, bus.out_result, 32'd0);
        check({tag, "_read_data"}, bus.out_read_data, 32'd0);
        check({tag, "_misalign"}, 32'(bus.out_misalign), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    localparam logic [31:0] WORD = 32'h8070_F0A5;

    initial begin
        logic [31:0]     s_res;
        logic [RD_W-1:0] s_rd;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.in_valid = 1'b0; bus.in_reg_write = 1'b0; bus.in_mem_to_rgs = 1'b0;
        bus.in_rd = '0; bus.in_result = '0; bus.in_read_data = '0;
        bus.in_funct3 = '0; bus.in_addr_lo = '0; bus.flush = 1'b0; bus.stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        idle(1'b0);

        // Load extraction
        apply(1'b1, 1'b1, 1'b1, 5'd3, 32'h1000_0000, WORD, 3'b000, 1'b0, 1'b0);
        check("lb_off0", bus.out_read_data, 32'hFFFF_FFA5);
        apply(1'b1, 1'b1, 1'b1, 5'd3, 32'h1000_0002, WORD, 3'b100, 1'b0, 1'b0);
        check("lbu_off2", bus.out_read_data, 32'h0000_0070);
        apply(1'b1, 1'b1, 1'b1, 5'd3, 32'h1000_0002, WORD, 3'b001, 1'b0, 1'b0);
        check("lh_off2", bus.out_read_data, 32'hFFFF_8070);
        apply(1'b1, 1'b1, 1'b1, 5'd3, 32'h1000_0000, WORD, 3'b010, 1'b0, 1'b0);
        check("lw_off0", bus.out_read_data, 32'h8070_F0A5);
        check("lw_reg_write", 32'(bus.out_reg_write), 32'd1);

        // Misalignment suppresses the write
        apply(1'b1, 1'b1, 1'b1, 5'd5, 32'h2000_0002, WORD, 3'b010, 1'b0, 1'b0);
        check("lw_mis", 32'(bus.out_misalign), 32'd1);
        check("lw_mis_rw", 32'(bus.out_reg_write), 32'd0);
        apply(1'b1, 1'b1, 1'b1, 5'd5, 32'h2000_0001, WORD, 3'b001, 1'b0, 1'b0);
        check("lh_mis", 32'(bus.out_misalign), 32'd1);
        check("lh_mis_rw", 32'(bus.out_reg_write), 32'd0);

        // Write to x0 is dropped
        apply(1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_1234, WORD, 3'b010, 1'b0, 1'b0);
        check("x0_valid", 32'(bus.out_valid), 32'd1);
        check("x0_rw", 32'(bus.out_reg_write), 32'd0);

        // Stall holds the entry
        apply(1'b1, 1'b1, 1'b0, 5'd9, 32'h1234_5678, 32'd0, 3'b010, 1'b0, 1'b0);
        s_res = bus.out_result;
        s_rd  = bus.out_rd;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_result", bus.out_result, s_res);
            check("stall_rd", 32'(bus.out_rd), 32'(s_rd));
`ifndef MEMWB_SKID_EN
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
`endif
        end

        // Flush with simultaneous transfer
        apply(1'b1, 1'b1, 1'b0, 5'd7, 32'h7777_7777, 32'd0, 3'b010, 1'b1, 1'b0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) idle(1'b0);

        // Reset mid-stream
        apply(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0004, WORD, 3'b010, 1'b0, 1'b0);
        check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        bus.stall = 1'b1;
        reset     = 1'b1;
        #1;
        check_zero("async_reset");
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1'b0);

`ifdef MEMWB_SKID_EN
        // A, B (while stalled) and C: B lands in skid, all three drain in order
        wb_log.delete();
        apply(1'b1, 1'b1, 1'b0, 5'd1, 32'hA, 32'd0, 3'b010, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 5'd2, 32'hB, 32'd0, 3'b010, 1'b0, 1'b1);
        check("skid_in_ready", 32'(bus.in_ready), 32'd0);
        apply(1'b1, 1'b1, 1'b0, 5'd3, 32'hC, 32'd0, 3'b010, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (bus.in_ready)
                break;
            apply(1'b1, 1'b1, 1'b0, 5'd3, 32'hC, 32'd0, 3'b010, 1'b0, 1'b0);
        end
        apply(1'b1, 1'b1, 1'b0, 5'd3, 32'hC, 32'd0, 3'b010, 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        check("skid_count", 32'(wb_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check("skid_order", (i < wb_log.size()) ? 32'(wb_log[i]) : 32'hDEAD, 32'(i + 1));
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            apply($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 5'($urandom),
                  $urandom, $urandom, 3'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 3);
        repeat (3) idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
